// File: rtl/antirrebote_defs.sv
// Shared definitions for the input-conditioning blocks: the 2-bit qualifier state
// encoding and how a state maps onto the debounced level.
package antirrebote_defs;

    localparam int SYNC_ETAPAS = 2;

    // Bit 1 of the encoding is the accepted level, so the output decode is a single wire.
    typedef enum logic [1:0] {
        BAJO        = 2'b00,
        ESPERA_ALTO = 2'b01,
        ALTO        = 2'b11,
        ESPERA_BAJO = 2'b10
    } estado_e;

    function automatic logic nivel_de(input estado_e estado);
        return estado[1];
    endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// One debounce channel: 2-flop synchronizer, qualification FSM with stability
// counter, and a rising-edge pulse aligned with the first cycle of level 1.
module antirrebote_canal
    import antirrebote_defs::*;
#(
    parameter int N_ESTABLE = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst_i,
    input  logic btn_i,
    output logic nivel_o,
    output logic sube_o
);

    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(N_ESTABLE - 1);

    logic [SYNC_ETAPAS-1:0] sync_q;
    estado_e                estado_q, estado_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sube_q, sube_d;
    logic                   s;

    assign s = sync_q[SYNC_ETAPAS-1];

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync_q   <= '0;
            estado_q <= BAJO;
            cnt_q    <= '0;
            sube_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_ETAPAS-2:0], btn_i};
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            sube_q   <= sube_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        case (estado_q)
            BAJO: begin
                if (s) begin
                    estado_d = ESPERA_ALTO;
                    cnt_d    = '0;
                end
            end
            ESPERA_ALTO: begin
                if (!s) begin
                    estado_d = BAJO;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_FIN) begin
                    estado_d = ALTO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ALTO: begin
                if (!s) begin
                    estado_d = ESPERA_BAJO;
                    cnt_d    = '0;
                end
            end
            ESPERA_BAJO: begin
                if (s) begin
                    estado_d = ALTO;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_FIN) begin
                    estado_d = BAJO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                estado_d = BAJO;
                cnt_d    = '0;
            end
        endcase
    end

    // Registered alongside the state so the pulse lands on the first cycle the level reads 1.
    assign sube_d = (estado_q == ESPERA_ALTO) && (estado_d == ALTO);

    assign nivel_o = nivel_de(estado_q);
    assign sube_o  = sube_q;

endmodule

// File: rtl/antirrebote.sv
// Two independent debounce channels for push-buttons A and B; the levels feed a
// downstream AND stage and each channel flags its own 0->1 transition.
module antirrebote #(
    parameter int N_ESTABLE = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_a,
    input  logic btn_b,
    output logic a,
    output logic b,
    output logic a_sube,
    output logic b_sube
);

    antirrebote_canal #(
        .N_ESTABLE (N_ESTABLE),
        .CNT_W     (CNT_W)
    ) u_canal_a (
        .clk     (clk),
        .rst_i   (rst),
        .btn_i   (btn_a),
        .nivel_o (a),
        .sube_o  (a_sube)
    );

    antirrebote_canal #(
        .N_ESTABLE (N_ESTABLE),
        .CNT_W     (CNT_W)
    ) u_canal_b (
        .clk     (clk),
        .rst_i   (rst),
        .btn_i   (btn_b),
        .nivel_o (b),
        .sube_o  (b_sube)
    );

endmodule

// File: tb/tb_antirrebote.sv
// Bench for antirrebote with N_ESTABLE=4: directed button sequences, a per-cycle
// comparison against a run-length model, and hand-computed timing checkpoints.
module tb_antirrebote;

    localparam int N  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst, btn_a, btn_b;
    logic a, b, a_sube, b_sube;

    int total = 0;
    int bad   = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    bit chk_on = 1'b0;

    antirrebote #(.N_ESTABLE(N), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_a  (btn_a),
        .btn_b  (btn_b),
        .a      (a),
        .b      (b),
        .a_sube (a_sube),
        .b_sube (b_sube)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: raw input delayed two edges; the level flips once the delayed input has
    // disagreed with it on N+1 consecutive edges, any agreement resets the run.
    logic [1:0] sh_m  [2];
    int         run_m [2];
    logic       lvl_m [2];
    logic       pul_m [2];

    always @(posedge clk) begin
        logic [1:0] raw_v;
        raw_v = {btn_b, btn_a};
        for (int ch = 0; ch < 2; ch++) begin
            if (rst) begin
                sh_m[ch]  <= 2'b00;
                run_m[ch] <= 0;
                lvl_m[ch] <= 1'b0;
                pul_m[ch] <= 1'b0;
            end else begin
                sh_m[ch]  <= {sh_m[ch][0], raw_v[ch]};
                pul_m[ch] <= 1'b0;
                if (sh_m[ch][1] != lvl_m[ch]) begin
                    if (run_m[ch] + 1 > N) begin
                        lvl_m[ch] <= sh_m[ch][1];
                        pul_m[ch] <= sh_m[ch][1];
                        run_m[ch] <= 0;
                    end else begin
                        run_m[ch] <= run_m[ch] + 1;
                    end
                end else begin
                    run_m[ch] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_a", a, lvl_m[0]);
            chk("model_b", b, lvl_m[1]);
            chk("model_a_sube", a_sube, pul_m[0]);
            chk("model_b_sube", b_sube, pul_m[1]);
            if (a_sube) pulses_a++;
            if (b_sube) pulses_b++;
        end
    end

    initial begin
        int pa0, pb0;
        rst   = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b0;
        wait_n(3);
        chk_on = 1'b1;
        chk("rst_a", a, 1'b0);
        chk("rst_b", b, 1'b0);
        chk("rst_a_sube", a_sube, 1'b0);
        chk("rst_b_sube", b_sube, 1'b0);
        rst = 1'b0;

        wait_n(20);
        chk("idle_a", a, 1'b0);
        chk("idle_b", b, 1'b0);
        chk_int("idle_pulses", pulses_a + pulses_b, 0);

        // Clean rise on A: level appears on the 7th negedge after driving (6 edges after sampling).
        pa0 = pulses_a;
        btn_a = 1'b1;
        wait_n(6);
        chk("a_pre_rise", a, 1'b0);
        wait_n(1);
        chk("a_rise", a, 1'b1);
        chk("a_sube_on", a_sube, 1'b1);
        chk("b_quiet", b, 1'b0);
        wait_n(1);
        chk("a_sube_off", a_sube, 1'b0);
        chk_int("a_rise_pulses", pulses_a - pa0, 1);

        btn_a = 1'b0;
        wait_n(12);
        chk("a_back_low", a, 1'b0);

        // Bounce 1,0,1,0 then hold: timing counts from the last 0->1.
        pa0 = pulses_a;
        btn_a = 1'b1; wait_n(1);
        btn_a = 1'b0; wait_n(1);
        btn_a = 1'b1; wait_n(1);
        btn_a = 1'b0; wait_n(1);
        btn_a = 1'b1;
        wait_n(6);
        chk("bounce_pre", a, 1'b0);
        wait_n(1);
        chk("bounce_rise", a, 1'b1);
        chk("bounce_sube", a_sube, 1'b1);
        wait_n(3);
        chk_int("bounce_pulses", pulses_a - pa0, 1);

        // Short low glitch is rejected.
        pa0 = pulses_a;
        btn_a = 1'b0;
        wait_n(3);
        btn_a = 1'b1;
        wait_n(12);
        chk("glitch_hold", a, 1'b1);

        // Sustained low: fall six edges after sampling, no pulse.
        btn_a = 1'b0;
        wait_n(6);
        chk("fall_pre", a, 1'b1);
        wait_n(1);
        chk("fall", a, 1'b0);
        wait_n(5);
        chk_int("fall_no_pulse", pulses_a - pa0, 0);

        // Simultaneous rise on both channels.
        pa0 = pulses_a;
        pb0 = pulses_b;
        btn_a = 1'b1;
        btn_b = 1'b1;
        wait_n(6);
        chk("and_pre", a & b, 1'b0);
        wait_n(1);
        chk("both_a", a, 1'b1);
        chk("both_b", b, 1'b1);
        chk("both_a_sube", a_sube, 1'b1);
        chk("both_b_sube", b_sube, 1'b1);
        chk("and_ab", a & b, 1'b1);
        wait_n(1);
        chk("and_ab_hold", a & b, 1'b1);
        chk_int("both_pulses", (pulses_a - pa0) + (pulses_b - pb0), 2);

        btn_a = 1'b0;
        btn_b = 1'b0;
        wait_n(12);
        chk("b_back_low", b, 1'b0);

        // Reset during B qualification, released with btn_b still high.
        pb0 = pulses_b;
        btn_b = 1'b1;
        wait_n(4);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_n(1);
            chk("rst_mid_b", b, 1'b0);
        end
        rst = 1'b0;
        wait_n(6);
        chk("post_rst_pre", b, 1'b0);
        wait_n(1);
        chk("post_rst_rise", b, 1'b1);
        chk("post_rst_sube", b_sube, 1'b1);
        wait_n(2);
        chk_int("post_rst_pulses", pulses_b - pb0, 1);
        chk("a_untouched", a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
